// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the RV32I ALU-control decoder: opcodes, func3 groups,
// the SUB func7 pattern and the 3-bit ALU operation codes.
package alu_ctrl_pkg;

  // ALU operation codes as seen by the execute-stage ALU.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  // Major opcodes (instruction[6:0]).
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // func3 values for the R-type / I-type ALU group.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // func3 values for the branch group.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] FUNC7_SUB = 7'b0100000;

  // func3 map shared by R-type and I-type; ADD/SUB selection is left to the caller.
  function automatic alu_op_t alu_func3_op(input logic [2:0] func3);
    alu_op_t op;
    op = ALU_ADD;
    case (func3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLT;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Branch compares: equality tests subtract, ordering tests use set-less-than.
  function automatic alu_op_t branch_func3_op(input logic [2:0] func3);
    alu_op_t op;
    op = ALU_SUB;
    case (func3)
      F3_BEQ, F3_BNE:                    op = ALU_SUB;
      F3_BLT, F3_BGE, F3_BLTU, F3_BGEU:  op = ALU_SLT;
      default:                           op = ALU_SUB;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational mapping of opcode/func3/func7 to an ALU operation code.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output alu_op_t    alu_op
);

  logic is_sub;

  assign is_sub = (func3 == F3_ADD_SUB) && (func7 == FUNC7_SUB);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (is_sub) alu_op = ALU_SUB;
        else        alu_op = alu_func3_op(func3);
      end
      // addi has no subtract form, so func7 never selects SUB here.
      OP_I:      alu_op = alu_func3_op(func3);
      OP_BRANCH: alu_op = branch_func3_op(func3);
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                 alu_op = ALU_ADD;
      default:   alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_control_unit.sv
// Execute-stage ALU control: decodes the current instruction and registers
// the ALU operation code, giving one clock of latency.
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic [6:0] opcode,
  output logic [2:0] alu_control
);

  alu_op_t alu_op_next;

  alu_ctrl_decode u_decode (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .alu_op (alu_op_next)
  );

  // Reset wins over decode so the ALU idles on ADD.
  always_ff @(posedge clk) begin
    if (rst) alu_control <= ALU_ADD;
    else     alu_control <= alu_op_next;
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: each step applies inputs away from the
// clock edge and checks the registered code before and after the next edge.
module tb_alu_control_unit;

  logic       clk;
  logic       rst;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [6:0] opcode;
  logic [2:0] alu_control;

  int checks;
  int errors;
  logic [2:0] prev_exp;

  alu_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .func3       (func3),
    .func7       (func7),
    .opcode      (opcode),
    .alu_control (alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input vector on the falling edge; the output must still show the
  // previous result until the rising edge, then the new expected code.
  task automatic step(input string tag, input logic r, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [2:0] exp, input logic check_hold);
    @(negedge clk);
    rst = r; opcode = op; func3 = f3; func7 = f7;
    #1;
    if (check_hold) begin
      checks++;
      assert (alu_control === prev_exp) else begin
        errors++;
        $error("FAIL %s_hold: observed %b expected %b", tag, alu_control, prev_exp);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    assert (alu_control === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, alu_control, exp);
    end
    $display("step %-12s rst=%b op=%b f3=%b f7=%b -> alu_control=%b (expected %b)",
             tag, r, op, f3, f7, alu_control, exp);
    prev_exp = exp;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_exp = 3'b010;
    rst = 1'b1; opcode = 7'b0110011; func3 = 3'b111; func7 = 7'b0000000;

    // 1. reset for two edges, then release
    step("rst_edge1",   1'b1, 7'b0110011, 3'b111, 7'b0000000, 3'b010, 1'b0);
    step("rst_edge2",   1'b1, 7'b0110011, 3'b111, 7'b0000000, 3'b010, 1'b1);
    step("rst_release", 1'b0, 7'b0110011, 3'b111, 7'b0000000, 3'b000, 1'b1);

    // 2. R-type
    step("r_or",        1'b0, 7'b0110011, 3'b110, 7'b0000000, 3'b001, 1'b1);
    step("r_add",       1'b0, 7'b0110011, 3'b000, 7'b0000000, 3'b010, 1'b1);
    step("r_sub",       1'b0, 7'b0110011, 3'b000, 7'b0100000, 3'b110, 1'b1);
    step("r_add_f7odd", 1'b0, 7'b0110011, 3'b000, 7'b0000001, 3'b010, 1'b1);
    step("r_xor",       1'b0, 7'b0110011, 3'b100, 7'b0000000, 3'b011, 1'b1);
    step("r_sll",       1'b0, 7'b0110011, 3'b001, 7'b0000000, 3'b100, 1'b1);
    step("r_sra_as_srl",1'b0, 7'b0110011, 3'b101, 7'b0100000, 3'b101, 1'b1);
    step("r_slt",       1'b0, 7'b0110011, 3'b010, 7'b0000000, 3'b111, 1'b1);
    step("r_sltu",      1'b0, 7'b0110011, 3'b011, 7'b0000000, 3'b111, 1'b1);
    step("r_and",       1'b0, 7'b0110011, 3'b111, 7'b0000000, 3'b000, 1'b1);

    // 3. store / addi with SUB func7 / load, plus other I-type ops
    step("store",       1'b0, 7'b0100011, 3'b010, 7'b0000000, 3'b010, 1'b1);
    step("addi_f7sub",  1'b0, 7'b0010011, 3'b000, 7'b0100000, 3'b010, 1'b1);
    step("load",        1'b0, 7'b0000011, 3'b010, 7'b0100000, 3'b010, 1'b1);
    step("i_xori",      1'b0, 7'b0010011, 3'b100, 7'b0000000, 3'b011, 1'b1);
    step("i_ori",       1'b0, 7'b0010011, 3'b110, 7'b0000000, 3'b001, 1'b1);
    step("i_srai",      1'b0, 7'b0010011, 3'b101, 7'b0100000, 3'b101, 1'b1);
    step("i_sltiu",     1'b0, 7'b0010011, 3'b011, 7'b0000000, 3'b111, 1'b1);

    // 4. branches
    step("blt",         1'b0, 7'b1100011, 3'b100, 7'b0000000, 3'b111, 1'b1);
    step("bge",         1'b0, 7'b1100011, 3'b101, 7'b0000000, 3'b111, 1'b1);
    step("beq",         1'b0, 7'b1100011, 3'b000, 7'b0000000, 3'b110, 1'b1);
    step("bne",         1'b0, 7'b1100011, 3'b001, 7'b0000000, 3'b110, 1'b1);
    step("bltu",        1'b0, 7'b1100011, 3'b110, 7'b0000000, 3'b111, 1'b1);
    step("bgeu",        1'b0, 7'b1100011, 3'b111, 7'b0000000, 3'b111, 1'b1);
    step("br_illegal",  1'b0, 7'b1100011, 3'b010, 7'b0000000, 3'b110, 1'b1);

    // 5. jumps, upper-immediate and illegal opcodes
    step("jal",         1'b0, 7'b1101111, 3'b111, 7'b0000000, 3'b010, 1'b1);
    step("r_and2",      1'b0, 7'b0110011, 3'b111, 7'b0000000, 3'b000, 1'b1);
    step("jalr",        1'b0, 7'b1100111, 3'b000, 7'b0000000, 3'b010, 1'b1);
    step("r_or2",       1'b0, 7'b0110011, 3'b110, 7'b0000000, 3'b001, 1'b1);
    step("lui",         1'b0, 7'b0110111, 3'b110, 7'b0100000, 3'b010, 1'b1);
    step("r_xor2",      1'b0, 7'b0110011, 3'b100, 7'b0000000, 3'b011, 1'b1);
    step("auipc",       1'b0, 7'b0010111, 3'b100, 7'b0000000, 3'b010, 1'b1);
    step("r_slt2",      1'b0, 7'b0110011, 3'b010, 7'b0000000, 3'b111, 1'b1);
    step("illegal_op",  1'b0, 7'b1111111, 3'b111, 7'b1111111, 3'b010, 1'b1);

    // 6. reset mid-stream while SUB is being decoded
    step("sub_pre",     1'b0, 7'b0110011, 3'b000, 7'b0100000, 3'b110, 1'b1);
    step("r_and3",      1'b0, 7'b0110011, 3'b111, 7'b0000000, 3'b000, 1'b1);
    step("rst_mid",     1'b1, 7'b0110011, 3'b000, 7'b0100000, 3'b010, 1'b1);
    step("sub_after",   1'b0, 7'b0110011, 3'b000, 7'b0100000, 3'b110, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
